// File: rtl/pipeline_hazard_ctrl.sv
// Hazard control for a 5-stage pipeline: forwarding, load-use and branch handling, memory-wait FSM with timeout halt.
// Optional stall-cycle counter port StallCount is built only when STALL_CNT_EN is defined.
module pipeline_hazard_ctrl #(
   parameter int MEM_TIMEOUT = 15,
   parameter int CNT_WIDTH   = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [4:0]           Rs1D,
   input  logic [4:0]           Rs2D,
   input  logic [4:0]           Rs1E,
   input  logic [4:0]           Rs2E,
   input  logic [4:0]           RdE,
   input  logic [1:0]           ResultSrcE,
   input  logic [4:0]           RdM,
   input  logic [4:0]           RdW,
   input  logic                 RegWriteM,
   input  logic                 RegWriteW,
   input  logic                 PCSrcE,
   input  logic                 MemReqM,
   input  logic                 MemReadyM,
   output logic                 StallF,
   output logic                 StallD,
   output logic                 StallE,
   output logic                 StallM,
   output logic                 FlushD,
   output logic                 FlushE,
   output logic                 FlushW,
   output logic [1:0]           ForwardAE,
   output logic [1:0]           ForwardBE,
`ifdef STALL_CNT_EN
   output logic [CNT_WIDTH-1:0] StallCount,
`endif
   output logic                 MemErr
);

   localparam int WW = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
   localparam logic [WW-1:0] TIMEOUT_W = WW'(MEM_TIMEOUT);

   typedef enum logic [1:0] {RUN, MEM_WAIT, ERR} state_t;

   state_t        state_q, state_d;
   logic [WW-1:0] wait_q, wait_d;
   logic          mem_err_q;
   logic          lw_stall;
   logic          mem_stall;

   assign lw_stall  = (ResultSrcE == 2'b01) && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));
   assign mem_stall = MemReqM && !MemReadyM && (state_q != ERR);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= RUN;
         wait_q    <= '0;
         mem_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         wait_q    <= wait_d;
         mem_err_q <= mem_err_q | (state_d == ERR);
      end
   end

   always_comb begin
      state_d = state_q;
      wait_d  = wait_q;
      case (state_q)
         RUN: begin
            wait_d = '0;
            if (mem_stall) state_d = MEM_WAIT;
         end
         MEM_WAIT: begin
            wait_d = (wait_q == TIMEOUT_W) ? wait_q : wait_q + 1'b1;
            if (!mem_stall)               state_d = RUN;
            else if (wait_d == TIMEOUT_W) state_d = ERR;
         end
         ERR:     state_d = ERR;
         default: state_d = RUN;
      endcase
   end

   // Reset overrides everything; ERR and memory wait freeze the whole pipe and bubble writeback.
   always_comb begin
      StallF    = 1'b0;
      StallD    = 1'b0;
      StallE    = 1'b0;
      StallM    = 1'b0;
      FlushD    = 1'b0;
      FlushE    = 1'b0;
      FlushW    = 1'b0;
      ForwardAE = 2'b00;
      ForwardBE = 2'b00;
      if (!rst_n) begin
         FlushD = 1'b1;
         FlushE = 1'b1;
         FlushW = 1'b1;
      end else begin
         if (RegWriteM && (RdM != 5'd0) && (RdM == Rs1E))      ForwardAE = 2'b10;
         else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs1E)) ForwardAE = 2'b01;
         if (RegWriteM && (RdM != 5'd0) && (RdM == Rs2E))      ForwardBE = 2'b10;
         else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs2E)) ForwardBE = 2'b01;

         if ((state_q == ERR) || mem_stall) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            FlushW = 1'b1;
         end else if (PCSrcE) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
         end else if (lw_stall) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
         end
      end
   end

   assign MemErr = mem_err_q;

`ifdef STALL_CNT_EN
   logic [CNT_WIDTH-1:0] stall_cnt_q;

   always_ff @(posedge clk) begin
      if (!rst_n)                        stall_cnt_q <= '0;
      else if (StallF && !(&stall_cnt_q)) stall_cnt_q <= stall_cnt_q + 1'b1;
   end

   assign StallCount = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed testbench for pipeline_hazard_ctrl; define STALL_CNT_EN to also check StallCount.
module tb_pipeline_hazard_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
   logic [1:0] ResultSrcE;
   logic       RegWriteM, RegWriteW, PCSrcE, MemReqM, MemReadyM;
   logic       StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemErr;
   logic [1:0] ForwardAE, ForwardBE;
`ifdef STALL_CNT_EN
   logic [31:0] StallCount;
`endif

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   pipeline_hazard_ctrl #(.MEM_TIMEOUT(15), .CNT_WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
      .ResultSrcE(ResultSrcE), .RdM(RdM), .RdW(RdW),
      .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .PCSrcE(PCSrcE),
      .MemReqM(MemReqM), .MemReadyM(MemReadyM),
      .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
      .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
      .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
`ifdef STALL_CNT_EN
      .StallCount(StallCount),
`endif
      .MemErr(MemErr)
   );

   // Pack the hazard outputs as {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW}.
   function automatic logic [6:0] hz();
      return {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW};
   endfunction

   task automatic clear_inputs();
      Rs1D = 5'd1; Rs2D = 5'd2; Rs1E = 5'd3; Rs2E = 5'd4; RdE = 5'd0;
      RdM = 5'd0; RdW = 5'd0; ResultSrcE = 2'b00;
      RegWriteM = 1'b0; RegWriteW = 1'b0; PCSrcE = 1'b0;
      MemReqM = 1'b0; MemReadyM = 1'b0;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      clear_inputs();
      rst_n = 1'b0;
      RdM = 5'd3; RegWriteM = 1'b1;
      next_cycle(); next_cycle(); #2;
      checks++;
      if (hz() !== 7'b0000111) begin errors++; $display("FAIL reset_hazard: got %b expected %b", hz(), 7'b0000111); end
      checks++;
      if (ForwardAE !== 2'b00) begin errors++; $display("FAIL reset_fwd: got %b expected 00", ForwardAE); end
      checks++;
      if (MemErr !== 1'b0) begin errors++; $display("FAIL reset_memerr: got %b expected 0", MemErr); end
      next_cycle();
      rst_n = 1'b1;
      clear_inputs();
      #2;
      checks++;
      if (hz() !== 7'b0000000) begin errors++; $display("FAIL idle_hazard: got %b expected %b", hz(), 7'b0); end
      $display("reset: hazard=%b fwdA=%b memerr=%b", hz(), ForwardAE, MemErr);
   endtask

   task automatic test_forwarding();
      next_cycle();
      Rs1E = 5'd5; Rs2E = 5'd5; RdM = 5'd5; RegWriteM = 1'b1; RdW = 5'd5; RegWriteW = 1'b1;
      #2;
      checks++;
      if (ForwardAE !== 2'b10) begin errors++; $display("FAIL fwdA_M_prio: got %b expected 10", ForwardAE); end
      checks++;
      if (ForwardBE !== 2'b10) begin errors++; $display("FAIL fwdB_M_prio: got %b expected 10", ForwardBE); end
      $display("fwd M+W: A=%b B=%b", ForwardAE, ForwardBE);
      next_cycle();
      RdM = 5'd0;
      #2;
      checks++;
      if (ForwardAE !== 2'b01) begin errors++; $display("FAIL fwdA_W: got %b expected 01", ForwardAE); end
      $display("fwd RdM=0: A=%b", ForwardAE);
      next_cycle();
      RdM = 5'd5; RegWriteM = 1'b0; Rs2E = 5'd6;
      #2;
      checks++;
      if (ForwardAE !== 2'b01) begin errors++; $display("FAIL fwdA_noRegWriteM: got %b expected 01", ForwardAE); end
      checks++;
      if (ForwardBE !== 2'b00) begin errors++; $display("FAIL fwdB_nomatch: got %b expected 00", ForwardBE); end
      $display("fwd W only: A=%b B=%b", ForwardAE, ForwardBE);
      next_cycle();
      RdW = 5'd0; Rs1E = 5'd0;
      #2;
      checks++;
      if (ForwardAE !== 2'b00) begin errors++; $display("FAIL fwdA_x0: got %b expected 00", ForwardAE); end
      $display("fwd x0: A=%b", ForwardAE);
      clear_inputs();
   endtask

   task automatic test_mem_wait();
      for (int i = 0; i < 3; i++) begin
         next_cycle();
         MemReqM = 1'b1; MemReadyM = 1'b0;
         #2;
         checks++;
         if (hz() !== 7'b1111001) begin errors++; $display("FAIL memwait_c%0d: got %b expected %b", i, hz(), 7'b1111001); end
         $display("memwait cycle %0d: hazard=%b", i, hz());
      end
      next_cycle();
      MemReadyM = 1'b1;
      #2;
      checks++;
      if (hz() !== 7'b0000000) begin errors++; $display("FAIL memwait_ready: got %b expected %b", hz(), 7'b0); end
      next_cycle();
      clear_inputs();
      RdE = 5'd9; ResultSrcE = 2'b01; Rs1D = 5'd9;
      PCSrcE = 1'b1;
      #2;
      checks++;
      if (hz() !== 7'b0000110) begin errors++; $display("FAIL memwait_back_run: got %b expected %b", hz(), 7'b0000110); end
      checks++;
      if (MemErr !== 1'b0) begin errors++; $display("FAIL memwait_memerr: got %b expected 0", MemErr); end
      $display("memwait done: hazard=%b memerr=%b", hz(), MemErr);
      clear_inputs();
   endtask

   task automatic test_load_use();
      next_cycle();
      ResultSrcE = 2'b01; RdE = 5'd7; Rs2D = 5'd7;
      #2;
      checks++;
      if (hz() !== 7'b1100010) begin errors++; $display("FAIL loaduse: got %b expected %b", hz(), 7'b1100010); end
      $display("load-use: hazard=%b", hz());
      next_cycle();
      clear_inputs();
      #2;
      checks++;
      if (hz() !== 7'b0000000) begin errors++; $display("FAIL loaduse_release: got %b expected %b", hz(), 7'b0); end
      next_cycle();
      ResultSrcE = 2'b01; RdE = 5'd0; Rs1D = 5'd0;
      #2;
      checks++;
      if (hz() !== 7'b0000000) begin errors++; $display("FAIL loaduse_x0: got %b expected %b", hz(), 7'b0); end
      next_cycle();
      ResultSrcE = 2'b00; RdE = 5'd7; Rs2D = 5'd7;
      #2;
      checks++;
      if (hz() !== 7'b0000000) begin errors++; $display("FAIL loaduse_notload: got %b expected %b", hz(), 7'b0); end
      $display("load-use negatives: hazard=%b", hz());
      clear_inputs();
   endtask

   task automatic test_branch();
      next_cycle();
      ResultSrcE = 2'b01; RdE = 5'd7; Rs1D = 5'd7; PCSrcE = 1'b1;
      #2;
      checks++;
      if (hz() !== 7'b0000110) begin errors++; $display("FAIL branch_over_lw: got %b expected %b", hz(), 7'b0000110); end
      $display("branch+lw: hazard=%b", hz());
      next_cycle();
      clear_inputs();
   endtask

   task automatic test_stall_count();
`ifdef STALL_CNT_EN
      #2;
      checks++;
      if (StallCount !== 32'd4) begin errors++; $display("FAIL stall_count: got %0d expected 4", StallCount); end
      $display("stall count: %0d", StallCount);
`endif
   endtask

   task automatic test_timeout();
      for (int i = 0; i < 20; i++) begin
         next_cycle();
         MemReqM = 1'b1; MemReadyM = 1'b0;
         #2;
         if (i == 9) begin
            checks++;
            if (MemErr !== 1'b0) begin errors++; $display("FAIL timeout_early: got %b expected 0", MemErr); end
         end
      end
      checks++;
      if (MemErr !== 1'b1) begin errors++; $display("FAIL timeout_memerr: got %b expected 1", MemErr); end
      checks++;
      if (hz() !== 7'b1111001) begin errors++; $display("FAIL timeout_hazard: got %b expected %b", hz(), 7'b1111001); end
      $display("timeout: memerr=%b hazard=%b", MemErr, hz());
      next_cycle();
      MemReqM = 1'b0; MemReadyM = 1'b1; PCSrcE = 1'b1;
      #2;
      checks++;
      if (hz() !== 7'b1111001) begin errors++; $display("FAIL err_sticky: got %b expected %b", hz(), 7'b1111001); end
      next_cycle();
      clear_inputs();
      rst_n = 1'b0;
      #2;
      checks++;
      if (hz() !== 7'b0000111) begin errors++; $display("FAIL err_reset_hazard: got %b expected %b", hz(), 7'b0000111); end
      next_cycle();
      rst_n = 1'b1;
      #2;
      checks++;
      if (MemErr !== 1'b0) begin errors++; $display("FAIL err_reset_memerr: got %b expected 0", MemErr); end
      checks++;
      if (hz() !== 7'b0000000) begin errors++; $display("FAIL err_reset_run: got %b expected %b", hz(), 7'b0); end
      next_cycle();
      ResultSrcE = 2'b01; RdE = 5'd7; Rs2D = 5'd7;
      #2;
      checks++;
      if (hz() !== 7'b1100010) begin errors++; $display("FAIL err_reset_lw: got %b expected %b", hz(), 7'b1100010); end
      $display("after reset: memerr=%b hazard=%b", MemErr, hz());
      clear_inputs();
   endtask

   initial begin
      test_reset();
      test_forwarding();
      test_mem_wait();
      test_load_use();
      test_branch();
      test_stall_count();
      test_timeout();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 15: maximum consecutive memory-wait cycles before the error halt.
REQ-002 SHALL have parameter CNT_WIDTH, default 32: width of the stall-cycle counter.
REQ-003 SHALL have ports clk (in, 1) and rst_n (in, 1); one clock, posedge; reset synchronous, active-low.
REQ-004 SHALL have Rs1D, Rs2D (in, 5): decode-stage source registers.
REQ-005 SHALL have Rs1E, Rs2E, RdE (in, 5): execute-stage sources and destination.
REQ-006 SHALL have ResultSrcE (in, 2): value 2'b01 marks a load in execute.
REQ-007 SHALL have RdM, RdW (in, 5) and RegWriteM, RegWriteW (in, 1): destinations and write enables in memory and writeback.
REQ-008 SHALL have PCSrcE (in, 1): taken branch or jump resolved in execute.
REQ-009 SHALL have MemReqM (in, 1): memory-stage access; MemReadyM (in, 1): data memory done.
REQ-010 SHALL have StallF, StallD, StallE, StallM (out, 1): hold the named pipeline register.
REQ-011 SHALL have FlushD, FlushE, FlushW (out, 1): bubble into the named pipeline register.
REQ-012 SHALL have ForwardAE, ForwardBE (out, 2): 00 register file, 10 from M, 01 from W.
REQ-013 SHALL have MemErr (out, 1): sticky timeout flag.
REQ-014 SHALL have StallCount (out, CNT_WIDTH) only when STALL_CNT_EN is defined.

Function
REQ-015 SHALL set ForwardAE=10 when RegWriteM, RdM!=0 and RdM==Rs1E; otherwise 01 when RegWriteW, RdW!=0 and RdW==Rs1E; otherwise 00. The M source has priority over W.
REQ-016 SHALL compute ForwardBE identically, using Rs2E.
REQ-017 SHALL compute lwStall = (ResultSrcE==01) and RdE!=0 and (RdE==Rs1D or RdE==Rs2D), combinationally.
REQ-018 SHALL use a three-state FSM: RUN, MEM_WAIT and ERR.
REQ-019 SHALL compute memStall = MemReqM and !MemReadyM, combinationally, in RUN and MEM_WAIT.
- Same-cycle effect: StallF, StallD, StallE and StallM=1 and FlushW=1.
- All other flushes are 0, and lwStall/PCSrcE effects are suppressed.
REQ-020 SHALL make these FSM transitions:
- RUN to MEM_WAIT on memStall.
- MEM_WAIT to RUN on MemReadyM or !MemReqM.
- MEM_WAIT to ERR when the wait counter reaches MEM_TIMEOUT with memStall still high.
REQ-021 SHALL clear the wait counter in RUN and increment it once per MEM_WAIT cycle; it saturates and does not wrap.
REQ-022 SHALL, in ERR, hold all four stalls and FlushW at 1 and MemErr at 1 until reset, regardless of inputs.
REQ-023 SHALL, with no memStall and lwStall only, assert StallF=StallD=1 and FlushE=1 for exactly the cycles lwStall is high (one cycle for an isolated load-use).
REQ-024 SHALL, with no memStall and PCSrcE=1, assert FlushD=FlushE=1 and StallF=StallD=0; PCSrcE overrides a simultaneous lwStall.
REQ-025 SHALL drive all stalls and flushes to 0 with no hazard; forwarding is active in every state.

Reset
REQ-026 SHALL, while rst_n=0 at posedge, set the FSM to RUN, the wait counter to 0, MemErr to 0 and StallCount to 0.
REQ-027 SHALL, while rst_n=0, drive all stalls 0, FlushD=FlushE=FlushW=1 and ForwardAE=ForwardBE=00.
REQ-028 SHALL, on reset during MEM_WAIT or ERR, resume in RUN on the first cycle after reset is released.

Configuration
REQ-029 SHALL, with STALL_CNT_EN defined, increment StallCount each cycle StallF=1 and rst_n=1.
- The count saturates at all-ones.
REQ-030 SHALL, without STALL_CNT_EN, omit the StallCount port and counter entirely; all other behaviour is identical.

Verification
REQ-031 SHALL cover: RdM=5, RegWriteM=1, RdW=5, RegWriteW=1, Rs1E=5 -> ForwardAE=10; RdM=0 variant -> ForwardAE=01.
REQ-032 SHALL cover: ResultSrcE=01, RdE=7, Rs2D=7 for 1 cycle -> StallF=StallD=FlushE=1 for that cycle only.
REQ-033 SHALL cover: lwStall and PCSrcE=1 together -> FlushD=FlushE=1, StallF=0.
REQ-034 SHALL cover: MemReqM=1 with MemReadyM low 3 cycles then high -> stalls and FlushW=1 for 3 cycles, back in RUN, MemErr=0.
REQ-035 SHALL cover: MemReadyM held low for 20 cycles (MEM_TIMEOUT=15) -> MemErr=1 and stalls stuck at 1; after a rst_n pulse -> MemErr=0 and RUN.
REQ-036 SHALL cover: with STALL_CNT_EN, the REQ-034 and REQ-032 sequence -> StallCount=4.
